// File: rtl/food_score_tracker_pkg.sv
// Shared constants, FSM encodings and tile type for the pellet score tracker.
package food_score_tracker_pkg;

  localparam int unsigned MAP_W          = 80;
  localparam int unsigned MAP_H          = 60;
  localparam int unsigned IDX_X_W        = 7;
  localparam int unsigned IDX_Y_W        = 6;
  localparam int unsigned SCORE_W        = 16;
  localparam int unsigned FOOD_W         = 12;
  localparam int unsigned LEVEL_W        = 4;
  localparam int unsigned FOOD_TOTAL_DEF = 300;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  typedef struct packed {
    logic [IDX_X_W-1:0] x;
    logic [IDX_Y_W-1:0] y;
  } tile_t;

  // Off-map coordinate so the first pellet of a level always compares unequal
  localparam tile_t TILE_INVALID = '{x: 7'h7F, y: 6'h3F};

  function automatic logic [7:0] to_bcd8(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// Four-digit BCD score plus two-digit BCD increment, clamped to 9999.
module bcd_add_sat (
  input  logic [15:0] a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] sum_c_o
);

  logic [15:0] b_ext;
  logic [15:0] sum_raw;
  logic [4:0]  dsum;
  logic        carry;

  assign b_ext = {8'h00, b_i};

  // Ripple one decimal digit at a time; a carry out of the top digit means overflow
  always_comb begin
    carry   = 1'b0;
    sum_raw = '0;
    dsum    = '0;
    for (int i = 0; i < 4; i++) begin
      dsum = 5'(a_i[4*i +: 4]) + 5'(b_ext[4*i +: 4]) + 5'(carry);
      if (dsum > 5'd9) begin
        dsum  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum_raw[4*i +: 4] = dsum[3:0];
    end
    sum_c_o = carry ? 16'h9999 : sum_raw;
  end

endmodule

// File: rtl/food_score_tracker.sv
// Counts each eaten pellet once, keeps BCD score / pellets left / level,
// and runs the IDLE / PLAY / CLEAR game FSM.
module food_score_tracker
  import food_score_tracker_pkg::*;
#(
  parameter int unsigned FOOD_TOTAL      = FOOD_TOTAL_DEF,
  parameter int unsigned POINTS_PER_FOOD = 10,
  parameter int unsigned MAX_LEVEL       = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [IDX_X_W-1:0] idx_x,
  input  logic [IDX_Y_W-1:0] idx_y,
  input  logic               is_food,
  input  logic               game_start,
  output logic [SCORE_W-1:0] score_bcd,
  output logic [FOOD_W-1:0]  food_left,
  output logic [LEVEL_W-1:0] level,
  output logic               eat_pulse,
  output logic               level_clear,
  output logic               playing
);

  localparam logic [7:0]         PTS_BCD  = to_bcd8(POINTS_PER_FOOD);
  localparam logic [FOOD_W-1:0]  FOOD_INIT = FOOD_W'(FOOD_TOTAL);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(MAX_LEVEL);

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d, score_sum;
  logic [FOOD_W-1:0]  food_q, food_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  tile_t              last_q, last_d, cur_tile;
  logic               eat_q, eat_d;
  logic               clear_q, clear_d;
  logic               play_q, play_d;
  logic               eat_c;

  bcd_add_sat u_add (
    .a_i     (score_q),
    .b_i     (PTS_BCD),
    .sum_c_o (score_sum)
  );

  assign cur_tile = '{x: idx_x, y: idx_y};
  // A held is_food on the same tile is the flush-stage latency, not a new pellet
  assign eat_c = (state_q == ST_PLAY) && tick && is_food && (cur_tile != last_q);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    food_d  = food_q;
    level_d = level_q;
    last_d  = last_q;
    eat_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (game_start) begin
          state_d = ST_PLAY;
          score_d = '0;
          level_d = LEVEL_W'(1);
          food_d  = FOOD_INIT;
          last_d  = TILE_INVALID;
        end
      end
      ST_PLAY: begin
        if (game_start) begin
          score_d = '0;
          level_d = LEVEL_W'(1);
          food_d  = FOOD_INIT;
          last_d  = TILE_INVALID;
        end else if (eat_c) begin
          last_d  = cur_tile;
          eat_d   = 1'b1;
          score_d = score_sum;
          food_d  = (food_q == '0) ? '0 : food_q - FOOD_W'(1);
          if (food_q == FOOD_W'(1)) state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (game_start) begin
          state_d = ST_PLAY;
          level_d = (level_q >= LVL_MAX) ? LVL_MAX : level_q + LEVEL_W'(1);
          food_d  = FOOD_INIT;
          last_d  = TILE_INVALID;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    clear_d = (state_d == ST_CLEAR);
    play_d  = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      food_q  <= '0;
      level_q <= '0;
      last_q  <= TILE_INVALID;
      eat_q   <= 1'b0;
      clear_q <= 1'b0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      food_q  <= food_d;
      level_q <= level_d;
      last_q  <= last_d;
      eat_q   <= eat_d;
      clear_q <= clear_d;
      play_q  <= play_d;
    end
  end

  assign score_bcd   = score_q;
  assign food_left   = food_q;
  assign level       = level_q;
  assign eat_pulse   = eat_q;
  assign level_clear = clear_q;
  assign playing     = play_q;

endmodule

// File: tb/tb_food_score_tracker.sv
// Self-checking bench: directed vector tables plus a randomized run against a score model.
module tb_food_score_tracker;

  localparam int A_FT = 300;
  localparam int A_PTS = 10;
  localparam int A_MAX = 15;
  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_CLEAR = 2;

  typedef struct {
    bit gs; bit tk; int x; int y; bit f;
    int score; int fl; int lvl; bit eat; bit clr; bit ply;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a_tick = 0, a_food = 0, a_gs = 0;
  logic [6:0] a_x = '0;
  logic [5:0] a_y = '0;
  logic [15:0] a_score;
  logic [11:0] a_fl;
  logic [3:0] a_lvl;
  logic a_eat, a_clr, a_ply;

  logic b_tick = 0, b_food = 0, b_gs = 0;
  logic [6:0] b_x = '0;
  logic [5:0] b_y = '0;
  logic [15:0] b_score;
  logic [11:0] b_fl;
  logic [3:0] b_lvl;
  logic b_eat, b_clr, b_ply;

  logic [34:0] a_out, b_out;
  assign a_out = {a_score, a_fl, a_lvl, a_eat, a_clr, a_ply};
  assign b_out = {b_score, b_fl, b_lvl, b_eat, b_clr, b_ply};

  int checks = 0;
  int failures = 0;

  int m_mode, m_score, m_food, m_level, m_last;
  bit m_eat;

  food_score_tracker u_a (
    .clk(clk), .rst_n(rst_n), .tick(a_tick), .idx_x(a_x), .idx_y(a_y),
    .is_food(a_food), .game_start(a_gs), .score_bcd(a_score), .food_left(a_fl),
    .level(a_lvl), .eat_pulse(a_eat), .level_clear(a_clr), .playing(a_ply)
  );

  food_score_tracker #(.FOOD_TOTAL(2), .POINTS_PER_FOOD(10), .MAX_LEVEL(2)) u_b (
    .clk(clk), .rst_n(rst_n), .tick(b_tick), .idx_x(b_x), .idx_y(b_y),
    .is_food(b_food), .game_start(b_gs), .score_bcd(b_score), .food_left(b_fl),
    .level(b_lvl), .eat_pulse(b_eat), .level_clear(b_clr), .playing(b_ply)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd16(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [34:0] pack(input int score, input int fl, input int lvl,
                                       input bit eat, input bit clr, input bit ply);
    return {bcd16(score), 12'(fl), 4'(lvl), eat, clr, ply};
  endfunction

  function automatic vec_t mk(input bit gs, input bit tk, input int x, input int y, input bit f,
                              input int score, input int fl, input int lvl,
                              input bit eat, input bit clr, input bit ply);
    vec_t v;
    v.gs = gs; v.tk = tk; v.x = x; v.y = y; v.f = f;
    v.score = score; v.fl = fl; v.lvl = lvl; v.eat = eat; v.clr = clr; v.ply = ply;
    return v;
  endfunction

  task automatic check(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got={score,food,lvl,eat,clr,ply}=%h required=%h", name, got, exp);
    end
  endtask

  task automatic apply_a(input bit gs, input bit tk, input int x, input int y, input bit f);
    a_gs = gs; a_tick = tk; a_x = 7'(x); a_y = 6'(y); a_food = f;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_b(input bit gs, input bit tk, input int x, input int y, input bit f);
    b_gs = gs; b_tick = tk; b_x = 7'(x); b_y = 6'(y); b_food = f;
    @(posedge clk);
    #1;
  endtask

  // Game rules in plain arithmetic: decimal score, tile key x*64+y, -1 = no tile yet
  task automatic model_step(input bit gs, input bit tk, input int x, input int y, input bit f);
    m_eat = 0;
    if (gs) begin
      if (m_mode == M_CLEAR) begin
        m_level = (m_level + 1 > A_MAX) ? A_MAX : m_level + 1;
      end else begin
        m_score = 0;
        m_level = 1;
      end
      m_food = A_FT;
      m_last = -1;
      m_mode = M_PLAY;
    end else if (m_mode == M_PLAY && tk && f && (x * 64 + y) != m_last) begin
      m_last = x * 64 + y;
      m_eat = 1;
      m_score = (m_score + A_PTS > 9999) ? 9999 : m_score + A_PTS;
      if (m_food == 1) m_mode = M_CLEAR;
      if (m_food > 0) m_food--;
    end
  endtask

  initial begin
    vec_t va[$];
    vec_t vb[$];
    bit gs, tk, f;
    int x, y;

    // Main game on the default map
    va.push_back(mk(1, 0, 0, 0, 0,  0, 300, 1, 0, 0, 1));
    va.push_back(mk(0, 1, 5, 3, 1, 10, 299, 1, 1, 0, 1));
    va.push_back(mk(0, 1, 5, 3, 1, 10, 299, 1, 0, 0, 1));
    va.push_back(mk(0, 1, 5, 3, 1, 10, 299, 1, 0, 0, 1));
    va.push_back(mk(0, 1, 5, 3, 1, 10, 299, 1, 0, 0, 1));
    va.push_back(mk(0, 0, 9, 9, 1, 10, 299, 1, 0, 0, 1));
    va.push_back(mk(0, 1, 6, 3, 1, 20, 298, 1, 1, 0, 1));
    va.push_back(mk(0, 1, 6, 3, 0, 20, 298, 1, 0, 0, 1));
    va.push_back(mk(0, 1, 5, 3, 1, 30, 297, 1, 1, 0, 1));
    va.push_back(mk(0, 1, 7, 3, 0, 30, 297, 1, 0, 0, 1));
    va.push_back(mk(1, 1, 8, 3, 1,  0, 300, 1, 0, 0, 1));
    va.push_back(mk(0, 1, 8, 3, 1, 10, 299, 1, 1, 0, 1));
    va.push_back(mk(0, 1, 127, 63, 1, 20, 298, 1, 1, 0, 1));
    va.push_back(mk(0, 0, 0, 0, 0, 20, 298, 1, 0, 0, 1));

    // Two-pellet map with level cap 2
    vb.push_back(mk(1, 0, 0, 0, 0,  0, 2, 1, 0, 0, 1));
    vb.push_back(mk(0, 1, 1, 1, 1, 10, 1, 1, 1, 0, 1));
    vb.push_back(mk(0, 1, 2, 1, 1, 20, 0, 1, 1, 1, 0));
    vb.push_back(mk(0, 1, 3, 1, 1, 20, 0, 1, 0, 1, 0));
    vb.push_back(mk(0, 1, 4, 1, 1, 20, 0, 1, 0, 1, 0));
    vb.push_back(mk(1, 0, 0, 0, 0, 20, 2, 2, 0, 0, 1));
    vb.push_back(mk(0, 1, 1, 1, 1, 30, 1, 2, 1, 0, 1));
    vb.push_back(mk(0, 1, 2, 1, 1, 40, 0, 2, 1, 1, 0));
    vb.push_back(mk(1, 0, 0, 0, 0, 40, 2, 2, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    check("reset_a", a_out, 35'd0);
    check("reset_b", b_out, 35'd0);
    rst_n = 1'b1;

    foreach (va[i]) begin
      apply_a(va[i].gs, va[i].tk, va[i].x, va[i].y, va[i].f);
      check($sformatf("vec_a%0d", i), a_out,
            pack(va[i].score, va[i].fl, va[i].lvl, va[i].eat, va[i].clr, va[i].ply));
    end
    apply_a(0, 0, 0, 0, 0);

    foreach (vb[i]) begin
      apply_b(vb[i].gs, vb[i].tk, vb[i].x, vb[i].y, vb[i].f);
      check($sformatf("vec_b%0d", i), b_out,
            pack(vb[i].score, vb[i].fl, vb[i].lvl, vb[i].eat, vb[i].clr, vb[i].ply));
    end
    apply_b(0, 0, 0, 0, 0);

    // Asynchronous reset mid-play, with an eat-qualifying tick already on the inputs
    a_tick = 1; a_x = 7'd20; a_y = 6'd20; a_food = 1;
    #1;
    rst_n = 1'b0;
    #2;
    check("async_rst_a", a_out, 35'd0);
    check("async_rst_b", b_out, 35'd0);
    apply_a(0, 0, 0, 0, 0);
    check("rst_held_a", a_out, 35'd0);
    rst_n = 1'b1;
    apply_a(0, 0, 0, 0, 0);
    check("post_rst_a", a_out, 35'd0);

    m_mode = M_IDLE; m_score = 0; m_food = 0; m_level = 0; m_last = -1; m_eat = 0;
    for (int cyc = 0; cyc < 9000; cyc++) begin
      if (m_mode == M_CLEAR) gs = ($urandom % 4) == 0;
      else if (m_mode == M_IDLE) gs = ($urandom % 8) == 0;
      else gs = (cyc < 2000) && (($urandom % 300) == 0);
      tk = ($urandom % 2) == 1;
      x = int'($urandom % 4);
      y = int'($urandom % 3);
      f = ($urandom % 4) != 0;
      model_step(gs, tk, x, y, f);
      apply_a(gs, tk, x, y, f);
      check($sformatf("rand_c%0d", cyc), a_out,
            pack(m_score, m_food, m_level, m_eat, m_mode == M_CLEAR, m_mode == M_PLAY));
    end
    apply_a(0, 0, 0, 0, 0);
    check("score_saturated", {a_score, 19'd0}, {16'h9999, 19'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
